// File: rtl/pipe_addsub_pkg.sv
// Shared helpers for the pipelined adder/subtractor: chunk sizing,
// per-stage bit ranges and parameter legality.
package pipe_addsub_pkg;

  // Bits handled per stage: ceil(width / stages).
  function automatic int chunk_w(int width, int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Lowest result bit produced by stage k (clamped to width for empty stages).
  function automatic int stage_lo(int k, int width, int stages);
    int lo;
    lo = k * chunk_w(width, stages);
    return (lo > width) ? width : lo;
  endfunction

  // Highest result bit produced by stage k; equals stage_lo-1 for an empty stage.
  function automatic int stage_hi(int k, int width, int stages);
    int hi;
    hi = (k + 1) * chunk_w(width, stages);
    return ((hi > width) ? width : hi) - 1;
  endfunction

  // WIDTH in 1..64, STAGES in 1..WIDTH.
  function automatic bit params_legal(int width, int stages);
    return (width >= 1) && (width <= 64) && (stages >= 1) && (stages <= width);
  endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// Combinational W-bit ripple adder built from the 1-bit full-adder cell.
// Exposes the carry into the chunk MSB so the caller can form signed overflow.

// 1-bit full-adder cell.
module pipe_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module pipe_addsub_chunk #(
  parameter int W = 15
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    pipe_addsub_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_addsub_nbit.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES ripple chunks with
// a global valid/ready stall. Each stage adds its chunk and forwards finished
// low sum bits and untouched high operand bits in staircase registers.
// Optional macro PIPE_ADDSUB_SAT_EN: saturate s to the signed max/min on overflow.
module pipe_addsub_nbit
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_addsub_nbit: WIDTH must be 1..64 and STAGES 1..WIDTH");
  end

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam int               LAST = STAGES - 1;

  // Stage registers.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             c_q     [STAGES];
  logic             ovf_q   [STAGES];

  // Per-stage inputs (previous stage or the port) and next-state values.
  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_sum   [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic             src_c     [STAGES];
  logic             src_ovf   [STAGES];
  logic [WIDTH-1:0] nxt_sum   [STAGES];
  logic [WIDTH-1:0] nxt_a     [STAGES];
  logic [WIDTH-1:0] nxt_b     [STAGES];
  logic             nxt_c     [STAGES];
  logic             nxt_ovf   [STAGES];

  logic en;

  // The whole pipe advances together unless a result is stuck at the output.
  assign en       = !valid_q[LAST] || out_ready;
  assign in_ready = en;

  // Stage 0 sees the port operands; subtract is a + ~b + 1.
  assign src_valid[0] = in_valid;
  assign src_sum[0]   = '0;
  assign src_a[0]     = a;
  assign src_b[0]     = sub ? ~b : b;
  assign src_c[0]     = sub ? 1'b1 : cin;
  assign src_ovf[0]   = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = stage_lo(k, WIDTH, STAGES);
    localparam int HI = stage_hi(k, WIDTH, STAGES);
    localparam int N  = HI - LO + 1;
    // Operand bits above this stage's chunk still need processing downstream.
    localparam logic [WIDTH-1:0] KEEP = ONES << (HI + 1);

    if (k > 0) begin : g_link
      assign src_valid[k] = valid_q[k-1];
      assign src_sum[k]   = sum_q[k-1];
      assign src_a[k]     = a_q[k-1];
      assign src_b[k]     = b_q[k-1];
      assign src_c[k]     = c_q[k-1];
      assign src_ovf[k]   = ovf_q[k-1];
    end

    assign nxt_a[k] = src_a[k] & KEEP;
    assign nxt_b[k] = src_b[k] & KEEP;

    if (N > 0) begin : g_add
      logic [N-1:0] ch_s;
      logic         ch_c;
      logic         ch_msb;

      pipe_addsub_chunk #(.W(N)) u_chunk (
        .a     (src_a[k][HI:LO]),
        .b     (src_b[k][HI:LO]),
        .cin   (src_c[k]),
        .s     (ch_s),
        .cout  (ch_c),
        .c_msb (ch_msb)
      );

      // Bits [HI:LO] of the incoming sum are still zero, so OR merges the chunk.
      assign nxt_sum[k] = src_sum[k] | (WIDTH'(ch_s) << LO);
      assign nxt_c[k]   = ch_c;
      // Overflow is formed in the stage holding the MSB and then forwarded.
      assign nxt_ovf[k] = (HI == WIDTH - 1) ? (ch_msb ^ ch_c) : src_ovf[k];
    end else begin : g_empty
      assign nxt_sum[k] = src_sum[k];
      assign nxt_c[k]   = src_c[k];
      assign nxt_ovf[k] = src_ovf[k];
    end
  end

  // Stage registers: all advance on en, bubbles included.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, not just valid bits, so s/cout/ovf
      // read zero during and right after reset.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        c_q[k]     <= 1'b0;
        ovf_q[k]   <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= src_valid[k];
        sum_q[k]   <= nxt_sum[k];
        a_q[k]     <= nxt_a[k];
        b_q[k]     <= nxt_b[k];
        c_q[k]     <= nxt_c[k];
        ovf_q[k]   <= nxt_ovf[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q[LAST];

`ifdef PIPE_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = ONES >> 1;
  localparam logic [WIDTH-1:0] SMIN = ~SMAX;

  // Saturate on overflow; a wrapped negative MSB means the true result was positive.
  always_comb begin
    // NOTE: default assignment first so no path leaves s unassigned (no latch).
    s = sum_q[LAST];
    if (ovf_q[LAST]) begin
      s = sum_q[LAST][WIDTH-1] ? SMAX : SMIN;
    end
  end
`else
  assign s = sum_q[LAST];
`endif

endmodule
